// File: rtl/operand_b_queue.sv
// rtl/operand_b_queue.sv - operand-B source select/negate feeding a 2-entry valid/ready queue
module operand_b_queue #(
  parameter int N_BUS = 16,
  parameter int N_IMM = 11
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [1:0]         i_sel,
  input  logic               i_sext,
  input  logic               i_neg,
  input  logic [N_BUS-1:0]   i_DATA,
  input  logic [N_IMM-1:0]   i_IMM,
  input  logic [N_BUS-1:0]   i_ACC,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [N_BUS-1:0]   o_MUL_B
);

  logic [N_BUS-1:0] imm_ext;
  logic [N_BUS-1:0] src;
  logic [N_BUS-1:0] val;
  logic [N_BUS-1:0] head;
  logic [N_BUS-1:0] tail;
  logic [1:0]       count;
  logic             acc;
  logic             pop;

  generate
    if (N_IMM < N_BUS) begin : g_ext
      assign imm_ext = {{(N_BUS-N_IMM){i_sext & i_IMM[N_IMM-1]}}, i_IMM};
    end else begin : g_noext
      assign imm_ext = i_IMM;
    end
  endgenerate

  always_comb begin
    src = '0;
    case (i_sel)
      2'd0:    src = i_DATA;
      2'd1:    src = imm_ext;
      2'd2:    src = i_ACC;
      default: src = '0;
    endcase
  end

  // Two's-complement negate; the most negative value wraps onto itself.
  assign val = i_neg ? ((~src) + {{(N_BUS-1){1'b0}}, 1'b1}) : src;

  assign o_ready = (count != 2'd2);
  assign o_valid = (count != 2'd0);
  assign acc     = i_valid & o_ready;
  assign pop     = o_valid & i_ready;
  assign o_MUL_B = o_valid ? head : '0;

  // head always holds the oldest entry; tail is only meaningful at count 2.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (i_flush) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (acc) begin
            head  <= val;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (acc && pop) begin
            head <= val;
          end else if (acc) begin
            tail  <= val;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head  <= tail;
            count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_b_queue.sv
// tb/tb_operand_b_queue.sv - randomized scoreboard bench for operand_b_queue
module tb_operand_b_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        valid;
  logic        ready_out;
  logic [1:0]  sel;
  logic        sext;
  logic        neg;
  logic [15:0] data;
  logic [10:0] imm;
  logic [15:0] accv;
  logic        valid_out;
  logic        rdy;
  logic [15:0] mul_b;

  int tests;
  int fails;

  logic [15:0] mq[$];
  bit          m_acc;
  bit          m_pop;

  operand_b_queue #(.N_BUS(16), .N_IMM(11)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .i_valid (valid),
    .o_ready (ready_out),
    .i_sel   (sel),
    .i_sext  (sext),
    .i_neg   (neg),
    .i_DATA  (data),
    .i_IMM   (imm),
    .i_ACC   (accv),
    .o_valid (valid_out),
    .i_ready (rdy),
    .o_MUL_B (mul_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_val(input logic [1:0] s, input logic se, input logic ng,
                                           input logic [15:0] d, input logic [10:0] im,
                                           input logic [15:0] a);
    int v;
    case (s)
      2'd0: v = int'(d);
      2'd1: begin
        v = int'(im);
        if (se && v >= 1024) v = v + 65536 - 2048;
      end
      2'd2: v = int'(a);
      default: v = 0;
    endcase
    if (ng) v = (65536 - v) % 65536;
    return v[15:0];
  endfunction

  // Scoreboard: a queue of at most two values, cleared by reset or flush.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      m_acc = valid && (mq.size() < 2);
      m_pop = (mq.size() > 0) && rdy;
      if (m_pop) void'(mq.pop_front());
      if (m_acc) mq.push_back(model_val(sel, sext, neg, data, imm, accv));
    end
  end

  always @(negedge clk) begin
    check("cyc_valid", {31'd0, valid_out}, {31'd0, mq.size() != 0});
    check("cyc_ready", {31'd0, ready_out}, {31'd0, mq.size() != 2});
    check("cyc_mul_b", {16'd0, mul_b}, {16'd0, (mq.size() != 0) ? mq[0] : 16'h0000});
  end

  task automatic drive(input logic v, input logic [1:0] s, input logic se, input logic ng,
                       input logic [15:0] d, input logic [10:0] im, input logic [15:0] a);
    valid = v; sel = s; sext = se; neg = ng; data = d; imm = im; accv = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; sel = 2'd0; sext = 1'b0; neg = 1'b0;
    data = '0; imm = '0; accv = '0; rdy = 1'b1;
    #3;
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_ready", {31'd0, ready_out}, 32'd1);
    check("rst_mul_b", {16'd0, mul_b}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Source and extension, then negation, streaming with i_ready held high.
    drive(1, 2'd1, 1, 0, 16'h0000, 11'h400, 16'h0000);
    check("imm_sext", {16'd0, mul_b}, 32'hFC00);
    drive(1, 2'd1, 0, 0, 16'h0000, 11'h400, 16'h0000);
    check("imm_zext", {16'd0, mul_b}, 32'h0400);
    drive(1, 2'd0, 0, 0, 16'h1234, 11'h000, 16'h0000);
    check("data_src", {16'd0, mul_b}, 32'h1234);
    drive(1, 2'd3, 0, 0, 16'hFFFF, 11'h7FF, 16'hFFFF);
    check("zero_src", {16'd0, mul_b}, 32'h0000);
    drive(1, 2'd2, 0, 1, 16'h0000, 11'h000, 16'h0005);
    check("neg_5", {16'd0, mul_b}, 32'hFFFB);
    drive(1, 2'd2, 0, 1, 16'h0000, 11'h000, 16'h8000);
    check("neg_min", {16'd0, mul_b}, 32'h8000);
    check("neg_min_valid", {31'd0, valid_out}, 32'd1);
    drive(1, 2'd2, 0, 1, 16'h0000, 11'h000, 16'h0000);
    check("neg_zero", {16'd0, mul_b}, 32'h0000);
    check("neg_zero_valid", {31'd0, valid_out}, 32'd1);
    drive(0, 2'd0, 0, 0, 16'h0000, 11'h000, 16'h0000);
    check("drain_valid", {31'd0, valid_out}, 32'd0);

    // Backpressure.
    rdy = 1'b0;
    drive(1, 2'd0, 0, 0, 16'h0001, 11'h000, 16'h0000);
    check("bp_a_ready", {31'd0, ready_out}, 32'd1);
    drive(1, 2'd0, 0, 0, 16'h0002, 11'h000, 16'h0000);
    check("bp_full_ready", {31'd0, ready_out}, 32'd0);
    drive(1, 2'd0, 0, 0, 16'h0003, 11'h000, 16'h0000);
    check("bp_c_dropped_head", {16'd0, mul_b}, 32'h0001);
    check("bp_c_dropped_ready", {31'd0, ready_out}, 32'd0);
    rdy = 1'b1;
    drive(0, 2'd0, 0, 0, 16'h0000, 11'h000, 16'h0000);
    check("bp_pop_a_head", {16'd0, mul_b}, 32'h0002);
    check("bp_pop_a_ready", {31'd0, ready_out}, 32'd1);
    drive(1, 2'd0, 0, 0, 16'h0003, 11'h000, 16'h0000);
    check("bp_c_after_b", {16'd0, mul_b}, 32'h0003);
    drive(0, 2'd0, 0, 0, 16'h0000, 11'h000, 16'h0000);
    check("bp_empty", {31'd0, valid_out}, 32'd0);

    // Simultaneous accept and pop at count 1, then flush at count 2.
    rdy = 1'b0;
    drive(1, 2'd0, 0, 0, 16'h0011, 11'h000, 16'h0000);
    rdy = 1'b1;
    drive(1, 2'd0, 0, 0, 16'h0022, 11'h000, 16'h0000);
    check("accpop_head", {16'd0, mul_b}, 32'h0022);
    check("accpop_ready", {31'd0, ready_out}, 32'd1);
    rdy = 1'b0;
    drive(1, 2'd0, 0, 0, 16'h0033, 11'h000, 16'h0000);
    check("pre_flush_full", {31'd0, ready_out}, 32'd0);
    rdy = 1'b1; flush = 1'b1;
    drive(1, 2'd0, 0, 0, 16'h0044, 11'h000, 16'h0000);
    flush = 1'b0;
    check("flush_valid", {31'd0, valid_out}, 32'd0);
    check("flush_mul_b", {16'd0, mul_b}, 32'h0);
    check("flush_ready", {31'd0, ready_out}, 32'd1);

    // Async reset while full.
    rdy = 1'b0;
    drive(1, 2'd0, 0, 0, 16'h00AA, 11'h000, 16'h0000);
    drive(1, 2'd0, 0, 0, 16'h00BB, 11'h000, 16'h0000);
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, valid_out}, 32'd0);
    check("midrst_ready", {31'd0, ready_out}, 32'd1);
    check("midrst_mul_b", {16'd0, mul_b}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random stream.
    for (int i = 0; i < 1500; i++) begin
      flush = ($urandom_range(0, 31) == 0);
      rdy   = ($urandom_range(0, 1) == 1);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 16'($urandom), 11'($urandom), 16'($urandom));
    end
    flush = 1'b0; valid = 1'b0; rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("final_empty", {31'd0, valid_out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
